// File: rtl/sample_burst_monitor.sv
// Receive-side checker for the gated burst sample clock: measures high/low run lengths, pulses
// per burst and silence gap against the programmed divider settings, with sticky error flags.
module sample_burst_monitor #(
  parameter int unsigned DIV_W  = 12,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned GAP_W  = 10,
  parameter int unsigned BCNT_W = 16
) (
  input  logic              HF_CLK,
  input  logic              RST_sync,
  input  logic              ENABLE,
  input  logic              SAMPLE_IN,
  input  logic              PHASE_IN,
  input  logic [DIV_W-1:0]  PHASE1DIV1_sync,
  input  logic [CNT_W-1:0]  PHASE1COUNT_sync,
  input  logic [GAP_W-1:0]  PHASE2COUNT_sync,
  input  logic              ERR_CLR,
  output logic              BURST_DONE,
  output logic [CNT_W:0]    BURST_PULSES,
  output logic [BCNT_W-1:0] BURST_CNT,
  output logic [3:0]        ERR_FLAGS
);

  typedef enum logic [2:0] {StIdle, StArmed, StHigh, StLow, StGap} state_e;

  localparam logic [CNT_W:0] CountOne = {{CNT_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              sample_q, phase_q;
  logic [DIV_W-1:0]  run_q, run_d;
  logic [CNT_W:0]    count_q, count_d;
  logic              burst_done_q;
  logic [CNT_W:0]    burst_pulses_q;
  logic [BCNT_W-1:0] burst_cnt_q;
  logic [3:0]        err_flags_q;

  logic           rise, fall, phase_rise, monitor_en, continuous;
  logic           end_burst, arm;
  logic [3:0]     err_new;
  logic [CNT_W:0] exp_count;

  assign rise       = SAMPLE_IN & ~sample_q;
  assign fall       = ~SAMPLE_IN & sample_q;
  assign phase_rise = PHASE_IN & ~phase_q;
  assign monitor_en = ENABLE && (PHASE1DIV1_sync != '0);
  assign continuous = (PHASE2COUNT_sync == '0);
  // A programmed count of zero means a full 2**CNT_W pulses per burst.
  assign exp_count  = (PHASE1COUNT_sync == '0) ? {1'b1, {CNT_W{1'b0}}}
                                               : {1'b0, PHASE1COUNT_sync};

  always_comb begin
    run_d = run_q;
    if (rise || fall) begin
      run_d = {{(DIV_W-1){1'b0}}, 1'b1};
    end else if (run_q != '1) begin
      run_d = run_q + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    end_burst = 1'b0;
    arm       = 1'b0;
    err_new   = '0;
    if (!monitor_en) begin
      // Dropping enable discards any partial burst without reporting it.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StArmed;
          arm     = 1'b1;
        end
        StArmed: begin
          if (rise) begin
            state_d = StHigh;
            count_d = CountOne;
          end
        end
        StHigh: begin
          if (fall) begin
            err_new[0] = (run_q != PHASE1DIV1_sync);
            if (PHASE_IN || (continuous && count_q == exp_count)) begin
              end_burst = 1'b1;
              if (continuous) begin
                state_d = StLow;
                count_d = '0;
              end else begin
                state_d = StGap;
              end
            end else begin
              state_d = StLow;
            end
          end
        end
        StLow: begin
          if (rise) begin
            err_new[1] = (run_q != PHASE1DIV1_sync);
            count_d    = (count_q != '1) ? count_q + CountOne : count_q;
            state_d    = StHigh;
          end else if (phase_rise) begin
            end_burst = 1'b1;
            state_d   = StGap;
          end
        end
        StGap: begin
          if (rise) begin
            err_new[3] = !continuous && (run_q != DIV_W'(PHASE2COUNT_sync));
            count_d    = CountOne;
            state_d    = StHigh;
          end
        end
        default: state_d = StIdle;
      endcase
      if (end_burst && count_q != exp_count) begin
        err_new[2] = 1'b1;
      end
    end
  end

  always_ff @(posedge HF_CLK) begin
    if (RST_sync) begin
      state_q        <= StIdle;
      sample_q       <= 1'b0;
      phase_q        <= 1'b0;
      run_q          <= '0;
      count_q        <= '0;
      burst_done_q   <= 1'b0;
      burst_pulses_q <= '0;
      burst_cnt_q    <= '0;
      err_flags_q    <= '0;
    end else begin
      state_q      <= state_d;
      sample_q     <= SAMPLE_IN;
      phase_q      <= PHASE_IN;
      run_q        <= run_d;
      count_q      <= count_d;
      burst_done_q <= end_burst;
      if (end_burst) begin
        burst_pulses_q <= count_q;
      end
      if (arm) begin
        burst_cnt_q <= '0;
      end else if (end_burst) begin
        burst_cnt_q <= burst_cnt_q + {{(BCNT_W-1){1'b0}}, 1'b1};
      end
      // A new error in the clearing cycle survives the clear.
      err_flags_q <= (ERR_CLR ? 4'b0000 : err_flags_q) | err_new;
    end
  end

  assign BURST_DONE   = burst_done_q;
  assign BURST_PULSES = burst_pulses_q;
  assign BURST_CNT    = burst_cnt_q;
  assign ERR_FLAGS    = err_flags_q;

endmodule

// File: tb/tb_sample_burst_monitor.sv
// Scoreboard bench for sample_burst_monitor: stimulus queues expected burst reports, a negedge
// monitor checks each BURST_DONE against the queue.
module tb_sample_burst_monitor;

  logic        HF_CLK, RST_sync, ENABLE, SAMPLE_IN, PHASE_IN, ERR_CLR;
  logic [11:0] PHASE1DIV1_sync;
  logic [3:0]  PHASE1COUNT_sync;
  logic [9:0]  PHASE2COUNT_sync;
  logic        BURST_DONE;
  logic [4:0]  BURST_PULSES;
  logic [15:0] BURST_CNT;
  logic [3:0]  ERR_FLAGS;

  sample_burst_monitor dut (
    .HF_CLK           (HF_CLK),
    .RST_sync         (RST_sync),
    .ENABLE           (ENABLE),
    .SAMPLE_IN        (SAMPLE_IN),
    .PHASE_IN         (PHASE_IN),
    .PHASE1DIV1_sync  (PHASE1DIV1_sync),
    .PHASE1COUNT_sync (PHASE1COUNT_sync),
    .PHASE2COUNT_sync (PHASE2COUNT_sync),
    .ERR_CLR          (ERR_CLR),
    .BURST_DONE       (BURST_DONE),
    .BURST_PULSES     (BURST_PULSES),
    .BURST_CNT        (BURST_CNT),
    .ERR_FLAGS        (ERR_FLAGS)
  );

  typedef struct {
    int pulses;
    int cnt;
    int flags;
    int interval;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_done = 0;
  bit   clr_pending = 0;

  initial HF_CLK = 1'b0;
  always #5 HF_CLK = ~HF_CLK;
  always @(posedge HF_CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge HF_CLK) begin
    if (BURST_DONE === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got pulses=%0d cnt=%0d expected no BURST_DONE (cycle %0d)",
                 BURST_PULSES, BURST_CNT, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_pulses", 32'(BURST_PULSES), e.pulses);
        chk("done_cnt", 32'(BURST_CNT), e.cnt);
        chk("done_flags", 32'(ERR_FLAGS), e.flags);
        if (e.interval != 0) chk("done_interval", cyc - last_done, e.interval);
      end
      last_done = cyc;
    end
  end

  task automatic expect_done(input int p, input int c, input int f, input int iv);
    exp_t e;
    e.pulses = p; e.cnt = c; e.flags = f; e.interval = iv;
    sb.push_back(e);
  endtask

  task automatic drive(input bit s, input bit p);
    SAMPLE_IN = s;
    PHASE_IN  = p;
    ERR_CLR   = clr_pending;
    clr_pending = 0;
    @(posedge HF_CLK);
    #1;
  endtask

  // n pulses of width hi separated by lo lows; pulse bad_idx is bad_hi wide; ends with gap lows.
  task automatic burst(input int hi, input int lo, input int n, input int gap, input bit gap_ph,
                       input int bad_idx, input int bad_hi);
    for (int i = 1; i <= n; i++) begin
      repeat ((i == bad_idx) ? bad_hi : hi) drive(1'b1, 1'b0);
      if (i < n) repeat (lo) drive(1'b0, 1'b0);
      else       repeat (gap) drive(1'b0, gap_ph);
    end
  endtask

  task automatic do_reset();
    RST_sync = 1'b1;
    ENABLE   = 1'b0;
    drive(1'b0, 1'b0);
    RST_sync = 1'b0;
  endtask

  task automatic start(input int div, input int cnt, input int p2);
    do_reset();
    PHASE1DIV1_sync  = 12'(div);
    PHASE1COUNT_sync = 4'(cnt);
    PHASE2COUNT_sync = 10'(p2);
    ENABLE = 1'b1;
    repeat (3) drive(1'b0, 1'b0);
  endtask

  task automatic chk_outputs(input string tag, input int d, input int p, input int c, input int f);
    @(negedge HF_CLK);
    chk({tag, "_done"}, 32'(BURST_DONE), d);
    chk({tag, "_pulses"}, 32'(BURST_PULSES), p);
    chk({tag, "_cnt"}, 32'(BURST_CNT), c);
    chk({tag, "_flags"}, 32'(ERR_FLAGS), f);
    @(posedge HF_CLK);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_sync = 1'b1; ENABLE = 1'b0; SAMPLE_IN = 1'b0; PHASE_IN = 1'b0; ERR_CLR = 1'b0;
    PHASE1DIV1_sync = '0; PHASE1COUNT_sync = '0; PHASE2COUNT_sync = '0;
    repeat (2) @(posedge HF_CLK);
    #1;
    RST_sync = 1'b0;
    chk_outputs("reset", 0, 0, 0, 0);

    // Three clean bursts.
    start(3, 4, 20);
    for (int b = 1; b <= 3; b++) begin
      expect_done(4, b, 0, 0);
      burst(3, 3, 4, 20, 1'b1, 0, 0);
    end

    // Long high on pulse 2: sticky high-width error, bursts still reported.
    start(3, 4, 20);
    expect_done(4, 1, 1, 0);
    burst(3, 3, 4, 20, 1'b1, 2, 4);
    expect_done(4, 2, 1, 0);
    burst(3, 3, 4, 20, 1'b1, 0, 0);

    // Continuous mode: a report every 4 cycles.
    start(1, 2, 0);
    for (int b = 1; b <= 4; b++) begin
      expect_done(2, b, 0, (b == 1) ? 0 : 4);
      burst(1, 1, 2, 1, 1'b0, 0, 0);
    end

    // Count 0 means 16 pulses; a 15-pulse burst flags a count error.
    start(2, 0, 5);
    expect_done(16, 1, 0, 0);
    burst(2, 2, 16, 5, 1'b1, 0, 0);
    expect_done(15, 2, 4, 0);
    burst(2, 2, 15, 5, 1'b1, 0, 0);

    // Short gap with ERR_CLR on the detecting rise: gap flag survives, then clears alone.
    start(3, 4, 20);
    expect_done(4, 1, 0, 0);
    burst(3, 3, 4, 19, 1'b1, 0, 0);
    clr_pending = 1;
    expect_done(4, 2, 8, 0);
    burst(3, 3, 4, 20, 1'b1, 0, 0);
    clr_pending = 1;
    drive(1'b0, 1'b0);
    chk_outputs("err_clr", 0, 4, 2, 0);

    // Enable drop mid-burst: no report, outputs held, runout ignored.
    start(3, 4, 20);
    expect_done(4, 1, 0, 0);
    burst(3, 3, 4, 20, 1'b1, 0, 0);
    repeat (3) drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    ENABLE = 1'b0;
    repeat (2) drive(1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b1);
    chk_outputs("disabled_hold", 0, 4, 1, 0);
    chk("sb_after_disable", sb.size(), 0);

    // Re-enable restarts the burst count from zero.
    ENABLE = 1'b1;
    repeat (3) drive(1'b0, 1'b0);
    expect_done(4, 1, 0, 0);
    burst(3, 3, 4, 20, 1'b1, 0, 0);

    // Reset mid-burst after an error clears everything.
    repeat (5) drive(1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0);
    chk_outputs("pre_reset", 0, 4, 1, 1);
    do_reset();
    chk_outputs("mid_reset", 0, 0, 0, 0);

    repeat (5) drive(1'b0, 1'b0);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
